// File: rtl/hram_ca_sequencer.sv
// HyperRAM command/address sequencer: turns byte-addressed burst requests into
// 48-bit CA words, splitting linear bursts at aligned SPLIT_WORDS boundaries.
module hram_ca_sequencer #(
  parameter int ADDR_W      = 32,
  parameter int LEN_W       = 10,
  parameter int SPLIT_WORDS = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic              req_reg,
  input  logic              req_wrap,
  input  logic [LEN_W-1:0]  req_len,
  output logic              ca_valid,
  input  logic              ca_ready,
  output logic [47:0]       ca_word,
  output logic [LEN_W-1:0]  ca_len,
  output logic              ca_last,
  output logic              err
);

  localparam int WA = ADDR_W - 1;
  localparam int SB = $clog2(SPLIT_WORDS);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t            state;
  logic [WA-1:0]     waddr;
  logic [LEN_W-1:0]  remaining;
  logic              is_write, is_reg, is_wrap;

  logic              unused_lsb;
  assign unused_lsb = req_addr[0];

  function automatic logic [47:0] make_ca(input logic wr, input logic rg,
                                          input logic wp, input logic [WA-1:0] wa);
    logic [31:0] w;
    w = 32'(wa);
    return {~wr, rg, ~wp, w[31:3], 13'd0, w[2:0]};
  endfunction

  // Linear segments stop at the next SPLIT_WORDS-aligned word address.
  function automatic logic [LEN_W-1:0] seg_len(input logic rg, input logic wp,
                                               input logic [WA-1:0] wa,
                                               input logic [LEN_W-1:0] rem);
    logic [LEN_W:0] room;
    room = (LEN_W+1)'(SPLIT_WORDS) - (LEN_W+1)'(wa[SB-1:0]);
    if (rg)
      return LEN_W'(1);
    else if (wp)
      return rem;
    else if ((LEN_W+1)'(rem) < room)
      return rem;
    else
      return room[LEN_W-1:0];
  endfunction

  logic [WA-1:0]    acc_wa, nxt_wa;
  logic [LEN_W-1:0] acc_seg, nxt_rem, nxt_seg;
  logic             acc_last, nxt_last;

  always_comb begin
    acc_wa   = req_addr[ADDR_W-1:1];
    acc_seg  = seg_len(req_reg, req_wrap, acc_wa, req_len);
    acc_last = req_reg | req_wrap | (acc_seg == req_len);
    nxt_wa   = waddr + WA'(ca_len);
    nxt_rem  = remaining - ca_len;
    nxt_seg  = seg_len(is_reg, is_wrap, nxt_wa, nxt_rem);
    nxt_last = (nxt_seg == nxt_rem);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      waddr     <= '0;
      remaining <= '0;
      is_write  <= 1'b0;
      is_reg    <= 1'b0;
      is_wrap   <= 1'b0;
      req_ready <= 1'b0;
      ca_valid  <= 1'b0;
      ca_word   <= '0;
      ca_len    <= '0;
      ca_last   <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            if (req_len == '0) begin
              err <= 1'b1;
            end else begin
              state     <= EMIT;
              req_ready <= 1'b0;
              waddr     <= acc_wa;
              remaining <= req_len;
              is_write  <= req_write;
              is_reg    <= req_reg;
              is_wrap   <= req_wrap;
              ca_valid  <= 1'b1;
              ca_word   <= make_ca(req_write, req_reg, req_wrap, acc_wa);
              ca_len    <= acc_seg;
              ca_last   <= acc_last;
            end
          end
        end
        EMIT: begin
          req_ready <= 1'b0;
          if (ca_valid && ca_ready) begin
            if (ca_last) begin
              state     <= IDLE;
              ca_valid  <= 1'b0;
              req_ready <= 1'b1;
            end else begin
              // Next segment goes out back-to-back with the handshake.
              waddr     <= nxt_wa;
              remaining <= nxt_rem;
              ca_word   <= make_ca(is_write, is_reg, is_wrap, nxt_wa);
              ca_len    <= nxt_seg;
              ca_last   <= nxt_last;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hram_ca_sequencer.sv
// Directed bench for hram_ca_sequencer with hand-computed CA words.
module tb_hram_ca_sequencer;

  localparam int ADDR_W = 32;
  localparam int LEN_W  = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write, req_reg, req_wrap;
  logic [LEN_W-1:0]  req_len;
  logic              ca_valid;
  logic              ca_ready;
  logic [47:0]       ca_word;
  logic [LEN_W-1:0]  ca_len;
  logic              ca_last;
  logic              err;

  int n_chk  = 0;
  int n_fail = 0;

  hram_ca_sequencer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .SPLIT_WORDS(128)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_reg(req_reg), .req_wrap(req_wrap), .req_len(req_len),
    .ca_valid(ca_valid), .ca_ready(ca_ready), .ca_word(ca_word),
    .ca_len(ca_len), .ca_last(ca_last), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ca(input string tag, input logic [47:0] w, input int len, input logic last);
    chk({tag, ".valid"}, 64'(ca_valid), 64'd1);
    chk({tag, ".word"},  64'(ca_word),  64'(w));
    chk({tag, ".len"},   64'(ca_len),   64'(len));
    chk({tag, ".last"},  64'(ca_last),  64'(last));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, 64'(ca_valid),  64'd0);
    chk({tag, ".ready"}, 64'(req_ready), 64'd1);
  endtask

  // Present a request, wait (bounded) for acceptance; returns at N+1 sample point.
  task automatic send(input logic [31:0] a, input logic wr, input logic rg,
                      input logic wp, input int len);
    int t;
    req_valid = 1'b1; req_addr = a; req_write = wr; req_reg = rg;
    req_wrap = wp; req_len = LEN_W'(len);
    t = 0;
    while (!req_ready && t < 50) begin
      step();
      t++;
    end
    if (!req_ready) chk("send.timeout", 64'd0, 64'd1);
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
    req_reg = 1'b0; req_wrap = 1'b0; req_len = '0; ca_ready = 1'b1;
    step();
    chk("rst.valid", 64'(ca_valid),  64'd0);
    chk("rst.word",  64'(ca_word),   64'd0);
    chk("rst.ready", 64'(req_ready), 64'd0);
    chk("rst.err",   64'(err),       64'd0);
    rst = 1'b0;
    step();
    chk("rst.ready_after", 64'(req_ready), 64'd1);

    // Linear read, single segment
    send(32'h100, 1'b0, 1'b0, 1'b0, 4);
    chk_ca("lin_rd", 48'hA000_0010_0000, 4, 1'b1);
    chk("lin_rd.busy", 64'(req_ready), 64'd0);
    step();
    chk_idle("lin_rd.done");

    // Linear write crossing a split boundary
    send(32'h0F0, 1'b1, 1'b0, 1'b0, 20);
    chk_ca("lin_wr.s1", 48'h2000_000F_0000, 8, 1'b0);
    step();
    chk_ca("lin_wr.s2", 48'h2000_0010_0000, 12, 1'b1);
    step();
    chk_idle("lin_wr.done");

    // Wrapped read: no splitting
    send(32'h106, 1'b0, 1'b0, 1'b1, 200);
    chk_ca("wrap_rd", 48'h8000_0010_0003, 200, 1'b1);
    step();
    chk_idle("wrap_rd.done");

    // Register write: always one word
    send(32'h2000, 1'b1, 1'b1, 1'b0, 5);
    chk_ca("reg_wr", 48'h6000_0200_0000, 1, 1'b1);
    step();
    chk_idle("reg_wr.done");

    // Backpressure on first segment
    ca_ready = 1'b0;
    send(32'h0F0, 1'b0, 1'b0, 1'b0, 20);
    for (int i = 0; i < 5; i++) begin
      chk_ca("bp.hold", 48'hA000_000F_0000, 8, 1'b0);
      chk("bp.ready", 64'(req_ready), 64'd0);
      step();
    end
    ca_ready = 1'b1;
    step();
    chk_ca("bp.s2", 48'hA000_0010_0000, 12, 1'b1);
    step();
    chk_idle("bp.done");

    // Top-of-space wrap: waddr 0x7FFF_FFFE, [44:16] = waddr[31:3] = 0x0FFF_FFFF
    send(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 4);
    chk_ca("top.s1", 48'hAFFF_FFFF_0006, 2, 1'b0);
    step();
    chk_ca("top.s2", 48'hA000_0000_0000, 2, 1'b1);
    step();
    chk_idle("top.done");

    // Zero-length request
    send(32'h400, 1'b0, 1'b0, 1'b0, 0);
    chk("zero.err",   64'(err),      64'd1);
    chk("zero.valid", 64'(ca_valid), 64'd0);
    step();
    chk("zero.err_pulse", 64'(err),      64'd0);
    chk("zero.valid2",    64'(ca_valid), 64'd0);

    // Reset during a 3-segment burst (128,128,44)
    ca_ready = 1'b0;
    send(32'h0, 1'b0, 1'b0, 1'b0, 300);
    chk_ca("mid.s1", 48'hA000_0000_0000, 128, 1'b0);
    rst = 1'b1;
    step();
    chk("mid.valid", 64'(ca_valid),  64'd0);
    chk("mid.word",  64'(ca_word),   64'd0);
    chk("mid.len",   64'(ca_len),    64'd0);
    chk("mid.last",  64'(ca_last),   64'd0);
    chk("mid.ready", 64'(req_ready), 64'd0);
    rst = 1'b0; ca_ready = 1'b1;
    step();
    chk_idle("mid.after");
    send(32'h100, 1'b0, 1'b0, 1'b0, 4);
    chk_ca("mid.fresh", 48'hA000_0010_0000, 4, 1'b1);
    step();
    chk_idle("mid.fresh_done");
    step();
    chk("mid.no_residual", 64'(ca_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
